core_dispatcher: RTL and testbench
==================================

CORE_DISPATCHER -- requirements
Module: core_dispatcher

Interface
REQ-001 Parameter CORES, default 4, number of worker cores; id width is $clog2(CORES).
REQ-002 Parameter TIMEOUT, default 16, maximum START cycles waiting for core_ack before abandoning.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 job_valid  input  1  job request pending.
REQ-007 job_addr  input  32  job entry address, valid with job_valid.
REQ-008 job_ready  output  1  job accepted this cycle when job_valid also high.
REQ-009 current_id  input  $clog2(CORES)  head of the idle-core queue.
REQ-010 current_valid  input  1  queue non-empty; current_id meaningful.
REQ-011 current_consume  output  1  one-cycle pop request to the idle-core queue.
REQ-012 core_start  output  CORES  one-hot start request to the selected core.
REQ-013 core_addr  output  32  job address presented to the selected core.
REQ-014 core_ack  input  CORES  per-core acknowledge of core_start.
REQ-015 dispatch_count  output  16  number of acknowledged dispatches, wraps modulo 2^16.
REQ-016 timeout_err  output  1  sticky flag: at least one dispatch timed out.

Function
REQ-017 FSM states IDLE, START, RELEASE; single state register.
REQ-018 job_ready SHALL be combinational: 1 iff state==IDLE and current_valid==1.
REQ-019 IDLE: on job_valid & job_ready, latch job_addr into addr_r and current_id into id_r, go to START; otherwise stay in IDLE.
REQ-020 START: core_start = one-hot(id_r), core_addr = addr_r; all other core_start bits 0.
REQ-021 core_addr SHALL hold addr_r in all states; it is meaningful only while core_start is nonzero.
REQ-022 START: wait counter clears on entry and increments each cycle START is held without acknowledge.
REQ-023 START: core_ack[id_r]==1 -> go to RELEASE, dispatch_count += 1.
REQ-024 core_ack bits other than id_r SHALL be ignored in all states.
REQ-025 START: wait counter == TIMEOUT-1 with no ack -> go to RELEASE, set timeout_err, dispatch_count unchanged.
REQ-026 Ack and timeout in the same cycle: ack wins, count increments, timeout_err unchanged.
REQ-027 RELEASE: current_consume=1 for exactly that cycle, then IDLE; current_consume is 0 in every other state.
REQ-028 A job is never accepted while current_valid==0; job_valid with an empty queue stalls, with job_ready=0.
REQ-029 current_id changes while in START or RELEASE SHALL NOT affect id_r.
REQ-030 Throughput: maximum one dispatch per 3 cycles (IDLE accept, START with immediate ack, RELEASE).
REQ-031 Exactly one current_consume per accepted job, whether the dispatch completes or times out.

Reset
REQ-032 reset==0 at a clock edge: state=IDLE, id_r=0, addr_r=0, wait counter=0.
REQ-033 Same reset edge: dispatch_count=0, timeout_err=0.
REQ-034 Outputs during and after reset: core_start=0, current_consume=0, job_ready=0 while reset is low.
REQ-035 Reset in START or RELEASE abandons the job without issuing current_consume.
REQ-036 timeout_err SHALL be cleared only by reset.

Verification
REQ-037 Basic dispatch: current_valid=1, current_id=2, job_valid=1, job_addr=0x1000; ack core 2 one cycle after START.
  -> core_start=4'b0100 and core_addr=0x1000 for 1 cycle, then current_consume pulses once, dispatch_count=1.
REQ-038 Empty queue stall: job_valid=1 with current_valid=0 for 5 cycles, then current_valid=1, current_id=1.
  -> job_ready=0 for 5 cycles; accepted on cycle 6; core_start=4'b0010.
REQ-039 Timeout: dispatch to core 3 with no ack.
  -> core_start=4'b1000 held 16 cycles, then current_consume pulses, timeout_err=1, dispatch_count unchanged.
REQ-040 Foreign ack: dispatch to core 0; assert core_ack=4'b0010 for 3 cycles, then 4'b0001.
  -> stays in START until the 4'b0001 cycle; exactly one consume.
REQ-041 Back-to-back: queue holds ids 0,1,2; 3 jobs continuously valid; immediate acks.
  -> starts to 0,1,2 at 3-cycle spacing, dispatch_count=3.
REQ-042 Reset mid-op: reset low while in START.
  -> next cycle core_start=0, no current_consume, dispatch_count=0, timeout_err=0.

Source files
------------

// File: rtl/core_dispatcher.sv
// -----------------------------------------------------------------------------
// core_dispatcher
//
// Hands incoming jobs to idle worker cores. A job is accepted only while the
// idle-core queue is non-empty; the head id is latched together with the job
// address, a one-hot start is raised towards that core until it acknowledges
// (or a wait budget runs out), and the queue head is then popped exactly once.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-low reset
//   job_valid       job request pending
//   job_addr[31:0]  job entry address, valid with job_valid
//   job_ready       job accepted this cycle when job_valid is also high
//   current_id      head of the idle-core queue
//   current_valid   idle-core queue non-empty
//   current_consume one-cycle pop of the idle-core queue
//   core_start      one-hot start request to the selected core
//   core_addr[31:0] job address presented to the selected core
//   core_ack        per-core acknowledge of core_start
//   dispatch_count  acknowledged dispatches, wraps modulo 2^16
//   timeout_err     sticky: at least one dispatch was abandoned
// -----------------------------------------------------------------------------
module core_dispatcher #(
  parameter int CORES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  input  logic [31:0]              job_addr,
  output logic                     job_ready,
  input  logic [$clog2(CORES)-1:0] current_id,
  input  logic                     current_valid,
  output logic                     current_consume,
  output logic [CORES-1:0]         core_start,
  output logic [31:0]              core_addr,
  input  logic [CORES-1:0]         core_ack,
  output logic [15:0]              dispatch_count,
  output logic                     timeout_err
);

  localparam int ID_W   = $clog2(CORES);
  // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [ID_W-1:0]     id_r, id_s;
  logic [31:0]         addr_r, addr_s;
  logic [WAIT_W-1:0]   wait_r, wait_s;
  logic [15:0]         count_r, count_s;
  logic                err_r, err_s;
  logic [CORES-1:0]    start_r, start_s;
  logic                consume_r, consume_s;
  logic                ready_s;
  logic                ack_hit_s;

  // Decode a core id into its one-hot start vector.
  function automatic logic [CORES-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [CORES-1:0] vec;
    vec      = {CORES{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Acceptance condition; gated by reset so the port reads 0 while reset is low.
  assign ready_s   = (state_r == ST_IDLE) && current_valid;
  assign job_ready = ready_s && reset;

  // Only the latched target may acknowledge; all other ack bits are ignored.
  assign ack_hit_s = core_ack[id_r];

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s   = state_r;
    id_s      = id_r;
    addr_s    = addr_r;
    wait_s    = wait_r;
    count_s   = count_r;
    err_s     = err_r;
    start_s   = {CORES{1'b0}};
    consume_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (job_valid && ready_s) begin
          state_s = ST_START;
          id_s    = current_id;
          addr_s  = job_addr;
          wait_s  = {WAIT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Ack is checked first so an ack on the last allowed cycle still counts.
        if (ack_hit_s) begin
          state_s = ST_RELEASE;
          count_s = count_r + 16'd1;
        end else if (wait_r == WAIT_W'(TIMEOUT - 1)) begin
          state_s = ST_RELEASE;
          err_s   = 1'b1;
        end else begin
          wait_s  = wait_r + WAIT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    if (state_s == ST_START) begin
      start_s = onehot(id_s);
    end else begin
      start_s = {CORES{1'b0}};
    end
    if (state_s == ST_RELEASE) begin
      consume_s = 1'b1;
    end else begin
      consume_s = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      id_r      <= {ID_W{1'b0}};
      addr_r    <= 32'd0;
      wait_r    <= {WAIT_W{1'b0}};
      count_r   <= 16'd0;
      err_r     <= 1'b0;
      start_r   <= {CORES{1'b0}};
      consume_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      id_r      <= id_s;
      addr_r    <= addr_s;
      wait_r    <= wait_s;
      count_r   <= count_s;
      err_r     <= err_s;
      start_r   <= start_s;
      consume_r <= consume_s;
    end
  end

  assign core_start      = start_r;
  assign current_consume = consume_r;
  assign core_addr       = addr_r;
  assign dispatch_count  = count_r;
  assign timeout_err     = err_r;

endmodule

// File: tb/tb_core_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_core_dispatcher
//
// Directed scenarios followed by random traffic. A job-lifecycle model tracks
// whether a job is in flight, how long it has waited and whether the pop is
// due; every cycle all outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_core_dispatcher;

  localparam int CORES   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic [31:0] job_addr;
  logic        job_ready;
  logic [1:0]  current_id;
  logic        current_valid;
  logic        current_consume;
  logic [3:0]  core_start;
  logic [31:0] core_addr;
  logic [3:0]  core_ack;
  logic [15:0] dispatch_count;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  // Job-lifecycle model
  bit          m_active;   // a job is being offered to a core
  bit          m_release;  // the queue pop is due this cycle
  bit          m_err;
  int          m_id;
  int          m_waited;   // start cycles already spent without ack
  int          m_count;
  logic [31:0] m_addr;

  int q[$];

  core_dispatcher #(.CORES(CORES), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .job_valid       (job_valid),
    .job_addr        (job_addr),
    .job_ready       (job_ready),
    .current_id      (current_id),
    .current_valid   (current_valid),
    .current_consume (current_consume),
    .core_start      (core_start),
    .core_addr       (core_addr),
    .core_ack        (core_ack),
    .dispatch_count  (dispatch_count),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_release = 1'b0;
    m_err     = 1'b0;
    m_id      = 0;
    m_waited  = 0;
    m_count   = 0;
    m_addr    = 32'd0;
  endtask

  task automatic check_model();
    logic [31:0] exp_start;
    exp_start = m_active ? (32'd1 << m_id) : 32'd0;
    chk("job_ready", {31'd0, job_ready},
        {31'd0, (reset === 1'b1) && !m_active && !m_release && (current_valid === 1'b1)});
    chk("core_start", {28'd0, core_start}, exp_start);
    chk("consume", {31'd0, current_consume}, {31'd0, m_release});
    chk("core_addr", core_addr, m_addr);
    chk("count", {16'd0, dispatch_count}, m_count % 65536);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
  endtask

  // Advance the lifecycle model by one clock edge using the current inputs.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else if (m_release) begin
      m_release = 1'b0;
    end else if (m_active) begin
      if (core_ack[m_id]) begin
        m_active  = 1'b0;
        m_release = 1'b1;
        m_count   = m_count + 1;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_active  = 1'b0;
        m_release = 1'b1;
        m_err     = 1'b1;
      end else begin
        m_waited  = m_waited + 1;
      end
    end else if (job_valid && current_valid) begin
      m_active = 1'b1;
      m_id     = int'(current_id);
      m_addr   = job_addr;
      m_waited = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pop;
    reset         = 1'b0;
    job_valid     = 1'b1;
    job_addr      = 32'hDEAD_BEEF;
    current_id    = 2'd3;
    current_valid = 1'b1;
    core_ack      = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;

    // Reset holds everything idle even with a job offered.
    cycle();
    cycle();
    chk("rst_ready", {31'd0, job_ready}, 32'd0);
    chk("rst_start", {28'd0, core_start}, 32'd0);
    chk("rst_count", {16'd0, dispatch_count}, 32'd0);
    reset     = 1'b1;
    job_valid = 1'b0;

    // Basic dispatch to core 2 with ack in the first start cycle.
    job_valid = 1'b1; job_addr = 32'h0000_1000; current_valid = 1'b1; current_id = 2'd2;
    cycle();
    job_valid = 1'b0; core_ack = 4'b0100;
    chk("t037_start", {28'd0, core_start}, 32'h4);
    chk("t037_addr", core_addr, 32'h1000);
    cycle();
    core_ack = 4'b0000;
    chk("t037_consume", {31'd0, current_consume}, 32'd1);
    cycle();
    chk("t037_count", {16'd0, dispatch_count}, 32'd1);
    chk("t037_once", {31'd0, current_consume}, 32'd0);

    // Empty-queue stall for 5 cycles, then accept to core 1.
    job_valid = 1'b1; job_addr = 32'h0000_2000; current_valid = 1'b0;
    repeat (5) begin
      cycle();
      chk("t038_stall", {31'd0, job_ready}, 32'd0);
    end
    current_valid = 1'b1; current_id = 2'd1;
    #1;
    chk("t038_ready", {31'd0, job_ready}, 32'd1);
    cycle();
    job_valid = 1'b0;
    chk("t038_start", {28'd0, core_start}, 32'h2);
    core_ack = 4'b0010;
    cycle();
    core_ack = 4'b0000;
    cycle();

    // Timeout on core 3: 16 start cycles, then one pop and the sticky error.
    job_valid = 1'b1; current_id = 2'd3; job_addr = $urandom;
    cycle();
    job_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("t039_held", {28'd0, core_start}, 32'h8);
      cycle();
    end
    chk("t039_consume", {31'd0, current_consume}, 32'd1);
    chk("t039_err", {31'd0, timeout_err}, 32'd1);
    chk("t039_count", {16'd0, dispatch_count}, 32'd2);
    cycle();
    chk("t039_idle", {28'd0, core_start}, 32'd0);

    // Foreign acks are ignored; only core 0's ack completes the dispatch.
    job_valid = 1'b1; current_id = 2'd0; job_addr = 32'h0000_4000;
    cycle();
    job_valid = 1'b0; core_ack = 4'b0010;
    repeat (3) begin
      chk("t040_wait", {28'd0, core_start}, 32'h1);
      cycle();
    end
    core_ack = 4'b0001;
    chk("t040_last", {28'd0, core_start}, 32'h1);
    cycle();
    core_ack = 4'b0000;
    chk("t040_consume", {31'd0, current_consume}, 32'd1);
    chk("t040_count", {16'd0, dispatch_count}, 32'd3);
    cycle();
    chk("t040_once", {31'd0, current_consume}, 32'd0);

    // Back-to-back: queue 0,1,2, jobs always valid, every core always acking.
    q = {0, 1, 2};
    job_valid = 1'b1; core_ack = 4'b1111;
    for (int it = 0; it < 12; it++) begin
      current_valid = (q.size() > 0);
      current_id    = (q.size() > 0) ? 2'(q[0]) : 2'd0;
      job_addr      = $urandom;
      if (it < 9) begin
        chk("t041_start", {28'd0, core_start},
            (it % 3 == 1) ? (32'd1 << (it / 3)) : 32'd0);
      end
      pop = m_release;
      cycle();
      if (pop && q.size() > 0) q.pop_front();
    end
    chk("t041_count", {16'd0, dispatch_count}, 32'd6);
    job_valid = 1'b0; core_ack = 4'b0000; current_valid = 1'b1;

    // Reset while in START abandons the job without a pop.
    job_valid = 1'b1; current_id = 2'd2; job_addr = 32'h0000_5000;
    cycle();
    job_valid = 1'b0;
    chk("t042_start", {28'd0, core_start}, 32'h4);
    reset = 1'b0;
    cycle();
    chk("t042_start0", {28'd0, core_start}, 32'd0);
    chk("t042_consume", {31'd0, current_consume}, 32'd0);
    chk("t042_count", {16'd0, dispatch_count}, 32'd0);
    chk("t042_err", {31'd0, timeout_err}, 32'd0);
    reset = 1'b1;
    cycle();
    chk("t042_nopop", {31'd0, current_consume}, 32'd0);

    // Random traffic against the model.
    repeat (600) begin
      reset         = ($urandom_range(0, 99) != 0);
      job_valid     = $urandom_range(0, 1) == 1;
      current_valid = ($urandom_range(0, 3) != 0);
      current_id    = 2'($urandom_range(0, 3));
      job_addr      = $urandom;
      core_ack      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
